// File: rtl/data_mem_controller.sv
// Purpose : M-stage load/store sequencer onto a valid/ready data-memory bus with lane formatting.
// Latency : store 2 cycles, load 3 cycles with zero bus wait; misaligned fault after 1 cycle;
//           timeout fault TIMEOUT_CYCLES+1 cycles after entering WAIT.
// Backpressure: request fields held stable until req_ready_i; stall_o holds the pipeline until DONE.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   mem_read_m_i / mem_write_m_i      load / store present in M stage
//   funct3_m_i, addr_m_i, wdata_m_i   width/sign, byte address, right-aligned store data
//   req_valid_o/req_ready_i/req_we_o/req_addr_o/req_be_o/req_wdata_o   bus request channel
//   resp_valid_i, resp_rdata_i        read response (loads only)
//   stall_o                           hold F/D/E/M pipeline registers
//   rdata_o, done_o, fault_o          completion result
module data_mem_controller #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read_m_i,
    input  logic        mem_write_m_i,
    input  logic [2:0]  funct3_m_i,
    input  logic [31:0] addr_m_i,
    input  logic [31:0] wdata_m_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic        req_we_o,
    output logic [31:0] req_addr_o,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wdata_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        fault_o
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    lat_off;
    logic [2:0]    lat_funct3;

    logic          op_present;
    logic          misaligned;
    logic [3:0]    be_fmt;
    logic [31:0]   wdata_fmt;

    assign op_present = mem_read_m_i | mem_write_m_i;

    // Not registered: the pipeline must freeze in the very cycle the op appears.
    assign stall_o = op_present && (state != DONE);

    // funct3[1:0] encodes width: 00 byte, 01 half, anything else treated as word.
    always_comb begin
        misaligned = 1'b0;
        be_fmt     = 4'b1111;
        wdata_fmt  = wdata_m_i;
        case (funct3_m_i[1:0])
            2'b00: begin
                be_fmt    = 4'b0001 << addr_m_i[1:0];
                wdata_fmt = {4{wdata_m_i[7:0]}};
            end
            2'b01: begin
                misaligned = addr_m_i[0];
                be_fmt     = 4'b0011 << addr_m_i[1:0];
                wdata_fmt  = {2{wdata_m_i[15:0]}};
            end
            default: begin
                misaligned = (addr_m_i[1:0] != 2'b00);
            end
        endcase
    end

    // Select the addressed lane of the raw word and extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_off     <= 2'b00;
            lat_funct3  <= 3'b000;
            req_valid_o <= 1'b0;
            req_we_o    <= 1'b0;
            req_addr_o  <= 32'b0;
            req_be_o    <= 4'b0;
            req_wdata_o <= 32'b0;
            rdata_o     <= 32'b0;
            done_o      <= 1'b0;
            fault_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_present) begin
                        if (misaligned) begin
                            state   <= DONE;
                            done_o  <= 1'b1;
                            fault_o <= 1'b1;
                            rdata_o <= 32'b0;
                        end else begin
                            state       <= REQ;
                            req_valid_o <= 1'b1;
                            req_we_o    <= mem_write_m_i;
                            req_addr_o  <= {addr_m_i[31:2], 2'b00};
                            req_be_o    <= be_fmt;
                            req_wdata_o <= wdata_fmt;
                            lat_off     <= addr_m_i[1:0];
                            lat_funct3  <= funct3_m_i;
                        end
                    end
                end
                REQ: begin
                    if (req_ready_i) begin
                        req_valid_o <= 1'b0;
                        if (req_we_o) begin
                            state   <= DONE;
                            done_o  <= 1'b1;
                            rdata_o <= 32'b0;
                        end else begin
                            state <= WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                WAIT: begin
                    // A response in the same cycle the limit is reached still wins.
                    if (resp_valid_i) begin
                        state   <= DONE;
                        done_o  <= 1'b1;
                        rdata_o <= extend_load(resp_rdata_i, lat_off, lat_funct3);
                    end else if (cnt == TMAX) begin
                        state   <= DONE;
                        done_o  <= 1'b1;
                        fault_o <= 1'b1;
                        rdata_o <= 32'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_o  <= 1'b0;
                    fault_o <= 1'b0;
                    cnt     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
module tb_data_mem_controller;

    logic        clk;
    logic        reset_n;
    logic        mem_read_m_i;
    logic        mem_write_m_i;
    logic [2:0]  funct3_m_i;
    logic [31:0] addr_m_i;
    logic [31:0] wdata_m_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        req_we_o;
    logic [31:0] req_addr_o;
    logic [3:0]  req_be_o;
    logic [31:0] req_wdata_o;
    logic        resp_valid_i;
    logic [31:0] resp_rdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        fault_o;

    int checks;
    int errors;

    data_mem_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_read_m_i (mem_read_m_i),
        .mem_write_m_i(mem_write_m_i),
        .funct3_m_i   (funct3_m_i),
        .addr_m_i     (addr_m_i),
        .wdata_m_i    (wdata_m_i),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .req_we_o     (req_we_o),
        .req_addr_o   (req_addr_o),
        .req_be_o     (req_be_o),
        .req_wdata_o  (req_wdata_o),
        .resp_valid_i (resp_valid_i),
        .resp_rdata_i (resp_rdata_i),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .done_o       (done_o),
        .fault_o      (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next cycle: inputs are driven 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if ({req_valid_o, req_we_o, done_o, fault_o, stall_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid/we/done/fault/stall=%b expected 00000",
                     {req_valid_o, req_we_o, done_o, fault_o, stall_o});
        end
        checks++;
        if ({req_addr_o, req_be_o, req_wdata_o, rdata_o} !== 100'b0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h be=%b wdata=%h rdata=%h expected all zero",
                     req_addr_o, req_be_o, req_wdata_o, rdata_o);
        end
        mem_write_m_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_op: got %b expected 1", stall_o);
        end
        mem_write_m_i = 1'b0;
        next_cycle();
        reset_n = 1'b1;
    endtask

    // Zero-wait load: request in cycle 1, response in cycle 2, done in cycle 3.
    task automatic test_load(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] resp, input logic [31:0] exp_rdata,
                             input logic [3:0] exp_be, input string name);
        next_cycle();
        mem_read_m_i = 1'b1; funct3_m_i = f3; addr_m_i = addr;
        req_ready_i = 1'b1; resp_valid_i = 1'b0;
        #1;
        checks++;
        if ({stall_o, req_valid_o, done_o} !== 3'b100) begin
            errors++;
            $display("FAIL %s_c0: got stall/valid/done=%b expected 100", name, {stall_o, req_valid_o, done_o});
        end
        next_cycle(); #1;
        checks++;
        if (req_valid_o !== 1'b1 || req_we_o !== 1'b0 || req_addr_o !== {addr[31:2], 2'b00} || req_be_o !== exp_be) begin
            errors++;
            $display("FAIL %s_req: got valid=%b we=%b addr=%h be=%b expected 1 0 %h %b",
                     name, req_valid_o, req_we_o, req_addr_o, req_be_o, {addr[31:2], 2'b00}, exp_be);
        end
        next_cycle();
        resp_valid_i = 1'b1; resp_rdata_i = resp;
        #1;
        checks++;
        if ({stall_o, req_valid_o, done_o} !== 3'b100) begin
            errors++;
            $display("FAIL %s_c2: got stall/valid/done=%b expected 100", name, {stall_o, req_valid_o, done_o});
        end
        next_cycle();
        resp_valid_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b1 || fault_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== exp_rdata) begin
            errors++;
            $display("FAIL %s_done: got done=%b fault=%b stall=%b rdata=%h expected 1 0 0 %h",
                     name, done_o, fault_o, stall_o, rdata_o, exp_rdata);
        end
        next_cycle();
        mem_read_m_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: got done=%b expected 0", name, done_o);
        end
    endtask

    task automatic test_timeout();
        next_cycle();
        mem_read_m_i = 1'b1; funct3_m_i = 3'b010; addr_m_i = 32'h500;
        req_ready_i = 1'b1; resp_valid_i = 1'b0;
        next_cycle(); #1;
        checks++;
        if (req_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL to_req: got valid=%b expected 1", req_valid_o);
        end
        // WAIT entered at cycle 2; done expected at cycle 7.
        for (int c = 2; c <= 6; c++) begin
            next_cycle(); #1;
            checks++;
            if (done_o !== 1'b0 || stall_o !== 1'b1) begin
                errors++;
                $display("FAIL to_wait_c%0d: got done=%b stall=%b expected 0 1", c, done_o, stall_o);
            end
        end
        next_cycle(); #1;
        checks++;
        if (done_o !== 1'b1 || fault_o !== 1'b1 || rdata_o !== 32'h0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL to_done: got done=%b fault=%b rdata=%h stall=%b expected 1 1 00000000 0",
                     done_o, fault_o, rdata_o, stall_o);
        end
        next_cycle();
        mem_read_m_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b0 || fault_o !== 1'b0 || req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL to_idle: got done=%b fault=%b valid=%b expected 0 0 0", done_o, fault_o, req_valid_o);
        end
    endtask

    task automatic test_store_backpressure();
        next_cycle();
        mem_write_m_i = 1'b1; funct3_m_i = 3'b001; addr_m_i = 32'h302; wdata_m_i = 32'h0000ABCD;
        req_ready_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 3) req_ready_i = 1'b1;
            #1;
            checks++;
            if (req_valid_o !== 1'b1 || req_we_o !== 1'b1 || req_addr_o !== 32'h300 ||
                req_be_o !== 4'b1100 || req_wdata_o !== 32'hABCDABCD || done_o !== 1'b0) begin
                errors++;
                $display("FAIL sh_req_c%0d: got valid=%b we=%b addr=%h be=%b wdata=%h done=%b expected 1 1 00000300 1100 abcdabcd 0",
                         c, req_valid_o, req_we_o, req_addr_o, req_be_o, req_wdata_o, done_o);
            end
        end
        next_cycle();
        req_ready_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b1 || fault_o !== 1'b0 || stall_o !== 1'b0 || req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL sh_done: got done=%b fault=%b stall=%b valid=%b expected 1 0 0 0",
                     done_o, fault_o, stall_o, req_valid_o);
        end
        next_cycle();
        mem_write_m_i = 1'b0;
    endtask

    task automatic test_misaligned(input logic wr, input logic [2:0] f3, input string name);
        next_cycle();
        mem_read_m_i = ~wr; mem_write_m_i = wr; funct3_m_i = f3; addr_m_i = 32'h401;
        req_ready_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1 || req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_c0: got stall=%b valid=%b expected 1 0", name, stall_o, req_valid_o);
        end
        next_cycle(); #1;
        checks++;
        if (done_o !== 1'b1 || fault_o !== 1'b1 || req_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_c1: got done=%b fault=%b valid=%b stall=%b expected 1 1 0 0",
                     name, done_o, fault_o, req_valid_o, stall_o);
        end
        next_cycle();
        mem_read_m_i = 1'b0; mem_write_m_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b0 || fault_o !== 1'b0 || req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_c2: got done=%b fault=%b valid=%b expected 0 0 0", name, done_o, fault_o, req_valid_o);
        end
    endtask

    task automatic test_sb_odd();
        next_cycle();
        mem_write_m_i = 1'b1; funct3_m_i = 3'b000; addr_m_i = 32'h401; wdata_m_i = 32'h1234565A;
        req_ready_i = 1'b1;
        next_cycle(); #1;
        checks++;
        if (req_valid_o !== 1'b1 || req_be_o !== 4'b0010 || req_wdata_o !== 32'h5A5A5A5A || req_addr_o !== 32'h400) begin
            errors++;
            $display("FAIL sb_req: got valid=%b be=%b wdata=%h addr=%h expected 1 0010 5a5a5a5a 00000400",
                     req_valid_o, req_be_o, req_wdata_o, req_addr_o);
        end
        next_cycle(); #1;
        checks++;
        if (done_o !== 1'b1 || fault_o !== 1'b0) begin
            errors++;
            $display("FAIL sb_done: got done=%b fault=%b expected 1 0", done_o, fault_o);
        end
        next_cycle();
        mem_write_m_i = 1'b0;
    endtask

    // sw completes in cycle 2; lw presented in cycle 3 must request in cycle 4.
    task automatic test_back_to_back();
        next_cycle();
        mem_write_m_i = 1'b1; funct3_m_i = 3'b010; addr_m_i = 32'h800; wdata_m_i = 32'hCAFEF00D;
        req_ready_i = 1'b1; resp_valid_i = 1'b0;
        next_cycle();
        next_cycle(); #1;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sw_done: got %b expected 1", done_o);
        end
        next_cycle();
        mem_write_m_i = 1'b0; mem_read_m_i = 1'b1; addr_m_i = 32'h804;
        #1;
        checks++;
        if (stall_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_c3: got stall=%b done=%b expected 1 0", stall_o, done_o);
        end
        next_cycle(); #1;
        checks++;
        if (req_valid_o !== 1'b1 || req_we_o !== 1'b0 || req_addr_o !== 32'h804) begin
            errors++;
            $display("FAIL b2b_lw_req: got valid=%b we=%b addr=%h expected 1 0 00000804",
                     req_valid_o, req_we_o, req_addr_o);
        end
        next_cycle();
        resp_valid_i = 1'b1; resp_rdata_i = 32'h01020304;
        next_cycle();
        resp_valid_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b1 || rdata_o !== 32'h01020304) begin
            errors++;
            $display("FAIL b2b_lw_done: got done=%b rdata=%h expected 1 01020304", done_o, rdata_o);
        end
        next_cycle();
        mem_read_m_i = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        next_cycle();
        mem_read_m_i = 1'b1; funct3_m_i = 3'b010; addr_m_i = 32'h600;
        req_ready_i = 1'b1; resp_valid_i = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b0;
        #1;
        checks++;
        if (req_valid_o !== 1'b0 || done_o !== 1'b0 || fault_o !== 1'b0 ||
            req_addr_o !== 32'h0 || req_be_o !== 4'b0 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait: got valid=%b done=%b fault=%b addr=%h be=%b stall=%b expected 0 0 0 00000000 0000 1",
                     req_valid_o, done_o, fault_o, req_addr_o, req_be_o, stall_o);
        end
        next_cycle();
        mem_read_m_i = 1'b0;
        reset_n = 1'b1;
        next_cycle();
        resp_valid_i = 1'b1; resp_rdata_i = 32'hFFFFFFFF;
        next_cycle();
        resp_valid_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b0 || req_valid_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_late_resp: got done=%b valid=%b rdata=%h expected 0 0 00000000", done_o, req_valid_o, rdata_o);
        end
        test_load(3'b010, 32'h700, 32'h12345678, 32'h12345678, 4'b1111, "lw_after_rst");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b1;
        mem_read_m_i = 1'b0; mem_write_m_i = 1'b0; funct3_m_i = 3'b000;
        addr_m_i = 32'h0; wdata_m_i = 32'h0;
        req_ready_i = 1'b0; resp_valid_i = 1'b0; resp_rdata_i = 32'h0;

        test_reset();
        test_load(3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, "lw");
        test_load(3'b000, 32'h203, 32'h80123456, 32'hFFFFFF80, 4'b1000, "lb");
        test_load(3'b100, 32'h203, 32'h80123456, 32'h00000080, 4'b1000, "lbu");
        test_load(3'b101, 32'h202, 32'h80123456, 32'h00008012, 4'b1100, "lhu");
        test_load(3'b001, 32'h200, 32'h80128765, 32'hFFFF8765, 4'b0011, "lh");
        test_timeout();
        test_store_backpressure();
        test_misaligned(1'b0, 3'b010, "lw_mis");
        test_misaligned(1'b1, 3'b001, "sh_mis");
        test_sb_odd();
        test_back_to_back();
        test_reset_in_wait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
